fetch_decode_stage: RTL and testbench

Front end of the 10-bit pipelined CPU. It owns the program counter, drives the instruction ROM address, and captures each fetched word into an IF/ID pipeline register together with its PC. It presents pre-split decode fields and pre-computed branch and jump targets to the execute stage. It handles stall, flush/redirect and fetch-side HALT stop, and replaces the bare PC-increment fetch path in front of the register file, ALU and EX/MEM registers.

---
 rtl/fetch_decode_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_decode_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
// Front end of the 10-bit pipelined CPU. Owns the program counter, drives the
// asynchronous instruction ROM, and captures each fetched word into the IF/ID
// register together with its PC. Decode fields and branch/jump targets are
// derived combinationally from IF/ID, so they add no latency.
//
// Flow control: there is no valid/ready handshake. id_valid qualifies the
// IF/ID contents on every cycle. 'stall' freezes all state. 'redirect' flushes
// IF/ID and reloads the PC, and it wins over 'stall' in the same cycle.
// Fetch-side HALT freezes the PC until a redirect arrives.

module fetch_decode_stage #(
  parameter int PC_W     = 10,
  parameter int INSTR_W  = 10,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  // Instruction ROM (combinational read)
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  // Pipeline control from downstream
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  // IF/ID register
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  // Pre-split decode fields
  output logic [2:0]         id_opcode,
  output logic [1:0]         id_rs,
  output logic [1:0]         id_rt,
  output logic               id_bank,
  output logic [1:0]         id_imm,
  // Pre-computed targets
  output logic [PC_W-1:0]    id_br_target,
  output logic [PC_W-1:0]    id_jmp_target,
  // Status
  output logic               fetch_stopped,
  output logic [CNT_W-1:0]   fetch_count
);

  // HALT is opcode 001 with immediate field 10
  localparam logic [2:0] OP_HALT  = 3'b001;
  localparam logic [1:0] IMM_HALT = 2'b10;

  // RUN: fetching normally. STOPPED: a HALT sits in (or passed through) IF/ID
  // and the PC is frozen until a redirect.
  typedef enum logic {
    S_RUN     = 1'b0,
    S_STOPPED = 1'b1
  } fetch_state_e;

  fetch_state_e       state_q,       state_d;
  logic [PC_W-1:0]    pc_q,          pc_d;
  logic               id_valid_q,    id_valid_d;
  logic [INSTR_W-1:0] id_instr_q,    id_instr_d;
  logic [PC_W-1:0]    id_pc_q,       id_pc_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic rom_is_halt;

  // Decode the word currently on the ROM bus for the HALT check
  always_comb begin
    rom_is_halt = (rom_data[9:7] == OP_HALT) && (rom_data[1:0] == IMM_HALT);
  end

  // Next-state selection: redirect > stall > stopped > fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Flush IF/ID; a wrong-path HALT is squashed by returning to RUN.
      // id_instr/id_pc keep their old (now meaningless) values.
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      state_d    = S_RUN;
    end else if (stall) begin
      // Everything holds
      state_d = state_q;
    end else if (state_q == S_STOPPED) begin
      // HALT has been handed on; drain the bubble and keep PC parked
      id_valid_d = 1'b0;
    end else begin
      id_instr_d    = rom_data;
      id_pc_d       = pc_q;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + CNT_W'(1);
      if (rom_is_halt) begin
        state_d = S_STOPPED;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= PC_W'(RESET_PC);
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs: registered state plus combinational decode of IF/ID
  always_comb begin
    rom_addr      = pc_q;
    id_valid      = id_valid_q;
    id_instr      = id_instr_q;
    id_pc         = id_pc_q;
    fetch_stopped = (state_q == S_STOPPED);
    fetch_count   = fetch_count_q;

    id_opcode = id_instr_q[9:7];
    id_rs     = id_instr_q[6:5];
    id_rt     = id_instr_q[4:3];
    id_bank   = id_instr_q[2];
    id_imm    = id_instr_q[1:0];

    // Branch target: PC plus zero-extended 2-bit immediate, wrapping
    id_br_target  = id_pc_q + {{(PC_W-2){1'b0}}, id_instr_q[1:0]};
    // Jump target: 7-bit field sign-extended from bit 6
    id_jmp_target = {{(PC_W-7){id_instr_q[6]}}, id_instr_q[6:0]};
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage
// Directed bench for fetch_decode_stage: straight-line fetch, stall, redirect
// with simultaneous stall, HALT stop/resume, PC and branch-target wrap, and
// asynchronous reset mid-run. Expected values are hand-computed constants.

module tb_fetch_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  rom_addr;
  logic [9:0]  rom_data;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        id_valid;
  logic [9:0]  id_instr;
  logic [9:0]  id_pc;
  logic [2:0]  id_opcode;
  logic [1:0]  id_rs;
  logic [1:0]  id_rt;
  logic        id_bank;
  logic [1:0]  id_imm;
  logic [9:0]  id_br_target;
  logic [9:0]  id_jmp_target;
  logic        fetch_stopped;
  logic [15:0] fetch_count;

  logic [9:0] rom [1024];
  assign rom_data = rom[rom_addr];

  fetch_decode_stage #(
    .PC_W(10), .INSTR_W(10), .RESET_PC(0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_bank(id_bank), .id_imm(id_imm),
    .id_br_target(id_br_target), .id_jmp_target(id_jmp_target),
    .fetch_stopped(fetch_stopped), .fetch_count(fetch_count)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if_id(input string tag, input logic v,
                             input logic [9:0] pc, input logic [9:0] instr,
                             input logic [15:0] cnt, input logic [9:0] addr);
    check_val({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
    if (v) begin
      check_val({tag, ".pc"},    {22'b0, id_pc},    {22'b0, pc});
      check_val({tag, ".instr"}, {22'b0, id_instr}, {22'b0, instr});
    end
    check_val({tag, ".count"}, {16'b0, fetch_count}, {16'b0, cnt});
    check_val({tag, ".addr"},  {22'b0, rom_addr},    {22'b0, addr});
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".addr"},    {22'b0, rom_addr},      32'h0);
    check_val({tag, ".valid"},   {31'b0, id_valid},      32'h0);
    check_val({tag, ".instr"},   {22'b0, id_instr},      32'h0);
    check_val({tag, ".pc"},      {22'b0, id_pc},         32'h0);
    check_val({tag, ".stopped"}, {31'b0, fetch_stopped}, 32'h0);
    check_val({tag, ".count"},   {16'b0, fetch_count},   32'h0);
    check_val({tag, ".opcode"},  {29'b0, id_opcode},     32'h0);
    check_val({tag, ".br"},      {22'b0, id_br_target},  32'h0);
    check_val({tag, ".jmp"},     {22'b0, id_jmp_target}, 32'h0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 10'h000;
    rom[0]     = 10'h001;
    rom[1]     = 10'h0C9;
    rom[2]     = 10'h1A3;
    rom[3]     = 10'h302;
    rom[5]     = 10'h0C2;   // HALT
    rom[8]     = 10'h040;   // jump field 0x40
    rom[10'h10]  = 10'h27F;
    rom[10'h3FF] = 10'h103; // BEQ imm 11

    stall = 1'b0; redirect = 1'b0; redirect_pc = 10'h000;

    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch
    step(); check_if_id("fetch0", 1'b1, 10'h000, 10'h001, 16'd1, 10'h001);
    step(); check_if_id("fetch1", 1'b1, 10'h001, 10'h0C9, 16'd2, 10'h002);
    step(); check_if_id("fetch2", 1'b1, 10'h002, 10'h1A3, 16'd3, 10'h003);
    check_val("dec.opcode", {29'b0, id_opcode}, 32'h3);
    check_val("dec.rs",     {30'b0, id_rs},     32'h1);
    check_val("dec.rt",     {30'b0, id_rt},     32'h0);
    check_val("dec.bank",   {31'b0, id_bank},   32'h0);
    check_val("dec.imm",    {30'b0, id_imm},    32'h3);
    check_val("dec.br",     {22'b0, id_br_target},  32'h005);
    check_val("dec.jmp",    {22'b0, id_jmp_target}, 32'h023);

    // Stall for three edges while id_pc = 2
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_if_id("stall", 1'b1, 10'h002, 10'h1A3, 16'd3, 10'h003);
    end
    stall = 1'b0;
    step(); check_if_id("unstall", 1'b1, 10'h003, 10'h302, 16'd4, 10'h004);

    // Run into HALT at address 5
    step(); check_if_id("fetch4", 1'b1, 10'h004, 10'h000, 16'd5, 10'h005);
    step(); check_if_id("halt", 1'b1, 10'h005, 10'h0C2, 16'd6, 10'h005);
    check_val("halt.stopped", {31'b0, fetch_stopped}, 32'h1);
    step(); check_if_id("halted1", 1'b0, 10'h000, 10'h000, 16'd6, 10'h005);
    check_val("halted1.stopped", {31'b0, fetch_stopped}, 32'h1);
    step(); check_if_id("halted2", 1'b0, 10'h000, 10'h000, 16'd6, 10'h005);

    // Redirect out of HALT to 0x08
    redirect = 1'b1; redirect_pc = 10'h008;
    step(); check_if_id("redir8", 1'b0, 10'h000, 10'h000, 16'd6, 10'h008);
    check_val("redir8.stopped", {31'b0, fetch_stopped}, 32'h0);
    redirect = 1'b0;
    step(); check_if_id("fetch8", 1'b1, 10'h008, 10'h040, 16'd7, 10'h009);
    check_val("fetch8.jmp", {22'b0, id_jmp_target}, 32'h3C0);

    // Redirect with simultaneous stall: redirect wins
    redirect = 1'b1; stall = 1'b1; redirect_pc = 10'h010;
    step(); check_if_id("redir10", 1'b0, 10'h000, 10'h000, 16'd7, 10'h010);
    redirect = 1'b0; stall = 1'b0;
    step(); check_if_id("fetch10", 1'b1, 10'h010, 10'h27F, 16'd8, 10'h011);
    // bit 6 of 0x27F is set, so the 7-bit field 0x7F sign-extends
    check_val("fetch10.jmp", {22'b0, id_jmp_target}, 32'h3FF);

    // PC and branch-target wrap at 0x3FF
    redirect = 1'b1; redirect_pc = 10'h3FF;
    step(); check_if_id("redir3ff", 1'b0, 10'h000, 10'h000, 16'd8, 10'h3FF);
    redirect = 1'b0;
    step(); check_if_id("fetch3ff", 1'b1, 10'h3FF, 10'h103, 16'd9, 10'h000);
    check_val("wrap.opcode", {29'b0, id_opcode},    32'h2);
    check_val("wrap.br",     {22'b0, id_br_target}, 32'h002);
    step(); check_if_id("fetch0b", 1'b1, 10'h000, 10'h001, 16'd10, 10'h001);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("areset");
    @(negedge clk);
    rst = 1'b0;
    step(); check_if_id("restart", 1'b1, 10'h000, 10'h001, 16'd1, 10'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
